// File: rtl/pcie_msi_pkg.sv
// Shared types and constants for the PCIe MSI interrupt controller.
// Vector widths are sized for the 32-vector MSI maximum.
package pcie_msi_pkg;

  localparam int MSI_MAX = 32;
  localparam int IDX_W   = 5;
  localparam int MM_W    = 3;
  localparam int PF_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    BACKOFF
  } msi_state_e;

  // Low-bit mask for the number of vectors the host granted (2^mm, max 32)
  function automatic logic [IDX_W-1:0] vec_mask(
    input logic [MM_W-1:0] mm
  );
    logic [IDX_W-1:0] m;
    m = '1;
    if (mm < 3'd5)
      m = IDX_W'((6'd1 << mm) - 6'd1);
    return m;
  endfunction

endpackage

// File: rtl/pcie_msi_rr_arb.sv
// Combinational round-robin pick: first request after last_grant,
// wrapping at N.
module pcie_msi_rr_arb
  import pcie_msi_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             grant_valid
);

  logic [IDX_W:0] idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, last_grant} + (IDX_W+1)'(1)
          + (IDX_W+1)'(i);
      if (idx >= (IDX_W+1)'(N))
        idx = idx - (IDX_W+1)'(N);
      if (!grant_valid && req[idx[IDX_W-1:0]]) begin
        grant       = idx[IDX_W-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_msi_irq_ctrl.sv
// Per-vector interrupt collector issuing MSIs to the PCIe hard block,
// one outstanding at a time, with retry after a reported failure.
module pcie_msi_irq_ctrl
  import pcie_msi_pkg::*;
#(
  parameter int MSI_COUNT   = 32,
  parameter int FUNC_NUM    = 0,
  parameter int RETRY_DELAY = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MSI_COUNT-1:0] irq,
  input  logic [3:0]           cfg_interrupt_msi_enable,
  input  logic [11:0]          cfg_interrupt_msi_mmenable,
  input  logic                 cfg_interrupt_msi_mask_update,
  input  logic [31:0]          cfg_interrupt_msi_data,
  output logic [3:0]           cfg_interrupt_msi_select,
  output logic [31:0]          cfg_interrupt_msi_int,
  output logic [31:0]          cfg_interrupt_msi_pending_status,
  output logic      cfg_interrupt_msi_pending_status_data_enable,
  output logic [3:0] cfg_interrupt_msi_pending_status_function_num,
  input  logic                 cfg_interrupt_msi_sent,
  input  logic                 cfg_interrupt_msi_fail,
  output logic [2:0]           cfg_interrupt_msi_attr,
  output logic                 cfg_interrupt_msi_tph_present,
  output logic [1:0]           cfg_interrupt_msi_tph_type,
  output logic [8:0]           cfg_interrupt_msi_tph_st_tag,
  output logic [3:0]           cfg_interrupt_msi_function_number,
  output logic [31:0]          msi_sent_count
);

  localparam int CNT_W = $clog2(RETRY_DELAY + 1);
  localparam logic [PF_W-1:0] FN = PF_W'(FUNC_NUM);

  msi_state_e state, state_nxt;

  logic [MSI_COUNT-1:0] pending, pending_nxt, mask;
  logic [MSI_COUNT-1:0] clr, fail_set, eligible;
  logic [IDX_W-1:0]     last_grant, grant_q;
  logic [IDX_W-1:0]     arb_grant, mapped;
  logic                 arb_valid, msi_en;
  logic [MM_W-1:0]      mm;
  logic [CNT_W-1:0]     bo_cnt;
  logic                 pend_chg, take_grant, ack_sent;
  logic [31:0]          sent_cnt;
  logic                 unused_in;

  assign msi_en   = cfg_interrupt_msi_enable[FUNC_NUM];
  assign mm       = cfg_interrupt_msi_mmenable[3*FUNC_NUM +: 3];
  assign eligible = pending & ~mask & {MSI_COUNT{msi_en}};
  assign mapped   = grant_q & vec_mask(mm);

  assign unused_in = ^{cfg_interrupt_msi_enable,
                       cfg_interrupt_msi_mmenable,
                       cfg_interrupt_msi_data};

  pcie_msi_rr_arb #(
    .N (MSI_COUNT)
  ) u_arb (
    .req         (eligible),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
    ack_sent   = 1'b0;
    clr        = '0;
    fail_set   = '0;
    cfg_interrupt_msi_int = '0;
    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          take_grant     = 1'b1;
          clr[arb_grant] = 1'b1;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        cfg_interrupt_msi_int = 32'd1 << mapped;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A simultaneous sent+fail is a failure
        if (cfg_interrupt_msi_fail) begin
          fail_set[grant_q] = 1'b1;
          state_nxt         = BACKOFF;
        end else if (cfg_interrupt_msi_sent) begin
          ack_sent  = 1'b1;
          state_nxt = IDLE;
        end
      end
      BACKOFF: begin
        if (bo_cnt == CNT_W'(RETRY_DELAY - 1))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pending_nxt = (pending & ~clr) | irq | fail_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      mask       <= '1;
      last_grant <= IDX_W'(MSI_COUNT - 1);
      grant_q    <= '0;
      bo_cnt     <= '0;
      pend_chg   <= 1'b0;
      sent_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      pend_chg <= (pending_nxt != pending);
      if (cfg_interrupt_msi_mask_update)
        mask <= cfg_interrupt_msi_data[MSI_COUNT-1:0];
      if (take_grant) begin
        last_grant <= arb_grant;
        grant_q    <= arb_grant;
      end
      if (state == BACKOFF)
        bo_cnt <= bo_cnt + CNT_W'(1);
      else
        bo_cnt <= '0;
      if (ack_sent)
        sent_cnt <= sent_cnt + 32'd1;
    end
  end

  assign cfg_interrupt_msi_pending_status = 32'(pending);
  assign cfg_interrupt_msi_pending_status_data_enable = pend_chg;
  assign cfg_interrupt_msi_pending_status_function_num = FN;
  assign cfg_interrupt_msi_select          = FN;
  assign cfg_interrupt_msi_function_number = FN;
  assign cfg_interrupt_msi_attr            = '0;
  assign cfg_interrupt_msi_tph_present     = 1'b0;
  assign cfg_interrupt_msi_tph_type        = '0;
  assign cfg_interrupt_msi_tph_st_tag      = '0;
  assign msi_sent_count                    = sent_cnt;

endmodule

// File: tb/tb_pcie_msi_irq_ctrl.sv
// Scenario bench for pcie_msi_irq_ctrl; MSI pulses are
// checked against a queue of expected one-hot values.
module tb_pcie_msi_irq_ctrl;

  localparam int RD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq;
  logic [3:0]  en;
  logic [11:0] mm;
  logic        mask_update;
  logic [31:0] msi_data;
  logic        sent, fail;
  logic [3:0]  sel, pfn, fnum;
  logic [31:0] msi_int, pstat, cnt;
  logic        pde, tph_present;
  logic [2:0]  attr;
  logic [1:0]  tph_type;
  logic [8:0]  st_tag;

  int          total = 0;
  int          bad = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  bit          ok;

  pcie_msi_irq_ctrl #(
    .MSI_COUNT   (32),
    .FUNC_NUM    (0),
    .RETRY_DELAY (RD)
  ) dut (
    .clk                              (clk),
    .rst_n                            (rst_n),
    .irq                              (irq),
    .cfg_interrupt_msi_enable         (en),
    .cfg_interrupt_msi_mmenable       (mm),
    .cfg_interrupt_msi_mask_update    (mask_update),
    .cfg_interrupt_msi_data           (msi_data),
    .cfg_interrupt_msi_select         (sel),
    .cfg_interrupt_msi_int            (msi_int),
    .cfg_interrupt_msi_pending_status (pstat),
    .cfg_interrupt_msi_pending_status_data_enable (pde),
    .cfg_interrupt_msi_pending_status_function_num (pfn),
    .cfg_interrupt_msi_sent           (sent),
    .cfg_interrupt_msi_fail           (fail),
    .cfg_interrupt_msi_attr           (attr),
    .cfg_interrupt_msi_tph_present    (tph_present),
    .cfg_interrupt_msi_tph_type       (tph_type),
    .cfg_interrupt_msi_tph_st_tag     (st_tag),
    .cfg_interrupt_msi_function_number (fnum),
    .msi_sent_count                   (cnt)
  );

  always #2 clk = ~clk;

  // Scoreboard: every MSI pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && msi_int !== 32'h0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got=%h want=none", msi_int);
      end else begin
        exp_v = exp_q.pop_front();
        if (msi_int !== exp_v) begin
          bad++;
          $display("FAIL sb_msi got=%h want=%h", msi_int, exp_v);
        end
      end
    end
  end

  task automatic serve(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (msi_int !== 32'h0) found = 1'b1;
    end
    if (found) begin
      @(negedge clk);
      sent = 1'b1;
      @(negedge clk);
      sent = 1'b0;
      exp_cnt++;
    end
  endtask

  task automatic set_mask(input logic [31:0] d);
    @(negedge clk);
    mask_update = 1'b1;
    msi_data    = d;
    @(negedge clk);
    mask_update = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (msi_int !== 32'h0 || pde !== 1'b0) begin
      bad++;
      $display("FAIL rst_out got=%h/%b want=0/0", msi_int, pde);
    end
    total++;
    if (cnt !== 32'h0 || pstat !== 32'h0) begin
      bad++;
      $display("FAIL rst_regs got=%h/%h want=0/0", cnt, pstat);
    end
    total++;
    if ({sel, pfn, fnum} !== 12'h0 || attr !== 3'h0
        || tph_present !== 1'b0 || tph_type !== 2'h0
        || st_tag !== 9'h0) begin
      bad++;
      $display("FAIL rst_const got=%h want=0", {sel, pfn, fnum});
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    irq = 32'h20;
    exp_q.push_back(32'h20);
    @(negedge clk);
    irq = 32'h0;
    total++;
    if (pde !== 1'b1 || pstat !== 32'h20) begin
      bad++;
      $display("FAIL single_pend got=%b/%h want=1/20", pde, pstat);
    end
    @(negedge clk);
    total++;
    if (msi_int !== 32'h20) begin
      bad++;
      $display("FAIL single_lat got=%h want=20", msi_int);
    end
    @(negedge clk);
    total++;
    if (msi_int !== 32'h0) begin
      bad++;
      $display("FAIL single_width got=%h want=0", msi_int);
    end
    sent = 1'b1;
    @(negedge clk);
    sent = 1'b0;
    exp_cnt++;
    total++;
    if (cnt !== 32'd1 || pstat !== 32'h0) begin
      bad++;
      $display("FAIL single_done got=%h/%h want=1/0", cnt, pstat);
    end
  endtask

  task automatic test_rr();
    @(negedge clk);
    irq = 32'h8;
    exp_q.push_back(32'h8);
    @(negedge clk);
    irq = 32'h0;
    serve(10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rr_first got=timeout want=msi");
    end
    @(negedge clk);
    irq = 32'h208;
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h8);
    @(negedge clk);
    irq = 32'h0;
    for (int k = 0; k < 2; k++) begin
      serve(10, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL rr_pair got=timeout want=msi%0d", k);
      end
    end
    total++;
    if (cnt !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL rr_cnt got=%0d want=%0d", cnt, exp_cnt);
    end
  endtask

  task automatic test_mmenable();
    mm = 12'd2;
    @(negedge clk);
    irq = 32'h40;
    exp_q.push_back(32'h4);
    @(negedge clk);
    irq = 32'h0;
    serve(10, ok);
    mm = 12'd5;
    total++;
    if (!ok || pstat !== 32'h0) begin
      bad++;
      $display("FAIL mm_map got=%b/%h want=1/0", ok, pstat);
    end
  endtask

  task automatic test_mask();
    set_mask(32'h2);
    @(negedge clk);
    irq = 32'h2;
    @(negedge clk);
    irq = 32'h0;
    total++;
    if (pde !== 1'b1 || pstat !== 32'h2) begin
      bad++;
      $display("FAIL mask_pend got=%b/%h want=1/2", pde, pstat);
    end
    repeat (6) @(negedge clk);
    total++;
    if (pstat !== 32'h2 || pde !== 1'b0) begin
      bad++;
      $display("FAIL mask_hold got=%h/%b want=2/0", pstat, pde);
    end
    exp_q.push_back(32'h2);
    set_mask(32'h0);
    serve(10, ok);
    total++;
    if (!ok || pstat !== 32'h0) begin
      bad++;
      $display("FAIL mask_release got=%b/%h want=1/0", ok, pstat);
    end
  endtask

  task automatic test_enable();
    en = 4'h0;
    @(negedge clk);
    irq = 32'h1;
    @(negedge clk);
    irq = 32'h0;
    repeat (5) @(negedge clk);
    total++;
    if (pstat !== 32'h1) begin
      bad++;
      $display("FAIL en_hold got=%h want=1", pstat);
    end
    exp_q.push_back(32'h1);
    en = 4'h1;
    serve(10, ok);
    total++;
    if (!ok || cnt !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL en_issue got=%0d want=%0d", cnt, exp_cnt);
    end
  endtask

  task automatic test_fail();
    int hit;
    @(negedge clk);
    irq = 32'h80;
    exp_q.push_back(32'h80);
    exp_q.push_back(32'h80);
    @(negedge clk);
    irq = 32'h0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (msi_int !== 32'h0) ok = 1'b1;
    end
    @(negedge clk);
    fail = 1'b1;
    hit = -1;
    for (int k = 1; k <= 40 && hit < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        fail = 1'b0;
        total++;
        if (pstat !== 32'h80) begin
          bad++;
          $display("FAIL fail_repend got=%h want=80", pstat);
        end
      end
      if (msi_int !== 32'h0) hit = k;
    end
    total++;
    if (!ok || hit != RD + 2) begin
      bad++;
      $display("FAIL fail_retry got=%0d want=%0d", hit, RD + 2);
    end
    @(negedge clk);
    sent = 1'b1;
    @(negedge clk);
    sent = 1'b0;
    exp_cnt++;
    total++;
    if (cnt !== 32'(exp_cnt) || pstat !== 32'h0) begin
      bad++;
      $display("FAIL fail_done got=%0d/%h want=%0d/0",
               cnt, pstat, exp_cnt);
    end
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    irq = 32'h10;
    exp_q.push_back(32'h10);
    @(negedge clk);
    irq = 32'h0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (msi_int !== 32'h0) ok = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    total++;
    if (!ok || cnt !== 32'h0 || pstat !== 32'h0
        || msi_int !== 32'h0 || pde !== 1'b0) begin
      bad++;
      $display("FAIL rstw_now got=%h/%h want=0/0", cnt, pstat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sent = 1'b1;
    @(negedge clk);
    sent = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (cnt !== 32'h0) begin
      bad++;
      $display("FAIL rstw_late got=%0d want=0", cnt);
    end
  endtask

  task automatic test_hold();
    set_mask(32'h0);
    @(negedge clk);
    irq = 32'h4;
    for (int k = 0; k < 3; k++)
      exp_q.push_back(32'h4);
    for (int k = 0; k < 3; k++) begin
      serve(10, ok);
      if (k == 1) irq = 32'h0;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL hold_msi got=timeout want=msi%0d", k);
      end
    end
    repeat (4) @(negedge clk);
    total++;
    if (cnt !== 32'd3 || pstat !== 32'h0) begin
      bad++;
      $display("FAIL hold_cnt got=%0d/%h want=3/0", cnt, pstat);
    end
  endtask

  initial begin
    irq         = '0;
    en          = 4'h1;
    mm          = 12'd5;
    mask_update = 1'b0;
    msi_data    = '0;
    sent        = 1'b0;
    fail        = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    set_mask(32'h0);
    test_single();
    test_rr();
    test_mmenable();
    test_mask();
    test_enable();
    test_fail();
    test_reset_wait();
    test_hold();
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
